serial_sub_engine: RTL and testbench
====================================

Name: serial_sub_engine

Overview:
- Bit-serial N-bit subtractor sequencer for the ALU lab datapath.
- Latches operands A, B and borrow-in, then feeds one bit pair per cycle (LSB first) into a 1-bit full-subtractor cell.
- Collects the difference bits and carries the borrow between cycles in a flop.
- Sits directly upstream of the full-subtractor cell, drives its a/b/bin inputs and consumes its d/bout outputs; presents the final N-bit result to the ALU result mux.

Parameters:
N, 4, operand/result width in bits (N >= 2)

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  request; sampled only while busy=0
a  input  N  minuend, captured on accepted start
b  input  N  subtrahend, captured on accepted start
bin  input  1  borrow-in, captured on accepted start
busy  output  1  high while state is RUN
done  output  1  one-cycle pulse when result becomes valid
diff  output  N  a - b - bin modulo 2^N; held until next accepted start
bout  output  1  final borrow-out; held with diff

Behaviour:
- Clock and reset are fixed: one clock, clk; reset rst_n is asynchronous and active-low.
- Reset, asynchronous on rst_n low:
  - state=IDLE, busy=0, done=0, diff=0, bout=0.
  - Operand shift registers, borrow flop and bit counter are cleared.
- States: IDLE, RUN, DONE.
- IDLE:
  - When start=1 at a rising edge, load a, b and bin into their registers, set cnt=0 and go to RUN.
  - When start=0, remain in IDLE.
- RUN, one bit per edge:
  - The cell sees a_sh[0], b_sh[0] and borrow flop.
  - Each edge shifts cell d into the result register MSB, with the result register shifting right.
  - Each edge latches cell bout into the borrow flop, shifts a_sh and b_sh right, and increments cnt.
  - At the edge where cnt==N-1: go to DONE, copy the result register to diff and the final borrow to bout.
- DONE:
  - done=1 for exactly this one cycle; busy=0.
  - Next edge goes to IDLE; if start=1 on that edge, it is accepted exactly as in IDLE, so back-to-back operation loses no cycle.
- Latency: start accepted at edge T0 gives done high in the cycle following edge TN, i.e. N cycles after acceptance. Throughput is one operation per N+1 cycles.
- Start while busy=1 is ignored; operand inputs are don't-care during RUN.
- diff and bout change only at the RUN->DONE edge or on reset. They hold stale values during RUN.
- rst_n assertion mid-RUN aborts immediately; no done pulse is produced.
- Arithmetic: unsigned modulo 2^N.
  - bout=1 iff a < b + bin, evaluated as unsigned with N+1 bits.
  - bin=1 with a=b gives diff=all ones, bout=1.
- cnt is ceil(log2 N) bits wide. It wraps only via reload on start, never during RUN.

Optional Feature:
- Macro: SERIAL_SUB_OVF_EN.
- Defined:
  - Adds output port ovf (1 bit), signed two's-complement overflow of a - b - bin.
  - Computed as (a[N-1] != b[N-1]) && (diff[N-1] != a[N-1]) using the captured MSBs.
  - Updated with diff; reset 0.
- Undefined: no ovf port and no extra registers; all other behaviour is identical.

Decomposition:
- Shared package alu_pkg:
  - enum type sub_state_t {IDLE, RUN, DONE}.
  - Localparam function for counter width, CNT_W = $clog2(N).
- One sub-module, fs_bit_cell:
  - Purely combinational 1-bit full subtractor with ports a, b, bin, d, bout.
  - d = a^b^bin; bout = (~a&b) | (~(a^b)&bin).
- The engine instantiates it once; no other hierarchy.

Test Plan:
- N=4, a=5, b=3, bin=0, start pulse: busy for 4 cycles, then done pulse; diff=2, bout=0.
- a=3, b=5, bin=0: diff=14 (4'hE), bout=1. Then a=0, b=0, bin=1: diff=15, bout=1.
- Start held high continuously with a=9, b=4: results 5 every 5 cycles. Start during RUN with a=1, b=1 changes nothing in the current result.
- rst_n low 2 cycles after accepted start: busy=0, diff=0, bout=0 immediately, no done. After release, a=7, b=2 gives diff=5.
- Random N=8 sweep, 1000 ops: diff and bout match the reference model (a-b-bin) mod 256 / borrow, and done count equals start-accept count.
- SERIAL_SUB_OVF_EN defined, N=4, a=4'b0111, b=4'b1000, bin=0: diff=4'b1111, bout=1, ovf=1. Then a=2, b=1 gives ovf=0.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared types for the ALU lab datapath: serial subtractor FSM states and
// the bit-counter width helper.
package alu_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } sub_state_t;

  // Counter width for an n-bit serial operation; n >= 2 keeps this at least 1.
  function automatic int cnt_width(input int n);
    return $clog2(n);
  endfunction

endpackage

// File: rtl/serial_sub_engine_if.sv
// Request/result bundle between the ALU sequencer and serial_sub_engine.
// With SERIAL_SUB_OVF_EN defined the bundle also carries the ovf flag.
interface serial_sub_engine_if #(
  parameter int N = 4
);

  logic         start;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic         bin;
  logic         busy;
  logic         done;
  logic [N-1:0] diff;
  logic         bout;
`ifdef SERIAL_SUB_OVF_EN
  logic         ovf;

  modport master (output start, a, b, bin,
                  input  busy, done, diff, bout, ovf);
  modport slave  (input  start, a, b, bin,
                  output busy, done, diff, bout, ovf);
`else
  modport master (output start, a, b, bin,
                  input  busy, done, diff, bout);
  modport slave  (input  start, a, b, bin,
                  output busy, done, diff, bout);
`endif

endinterface

// File: rtl/fs_bit_cell.sv
// Purely combinational 1-bit full subtractor: d = a - b - bin, bout = borrow.
module fs_bit_cell (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = a ^ b ^ bin;
  assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_sub_engine.sv
// Bit-serial N-bit subtractor: one bit pair per cycle, LSB first, through a
// single fs_bit_cell. Optional signed overflow output under SERIAL_SUB_OVF_EN.
module serial_sub_engine
  import alu_pkg::*;
#(
  parameter int N = 4
) (
  input logic                 clk,
  input logic                 rst_n,
  serial_sub_engine_if.slave  bus
);

  localparam int CNT_W = cnt_width(N);

  sub_state_t   state_q, state_d;
  logic [N-1:0] a_sh_q, a_sh_d;
  logic [N-1:0] b_sh_q, b_sh_d;
  logic [N-1:0] res_q, res_d;
  logic [N-1:0] diff_q, diff_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic         brw_q, brw_d;
  logic         bout_q, bout_d;
  logic         busy_q, busy_d;
  logic         done_q, done_d;

  logic cell_d, cell_bout;
  logic accept, last_bit;

  fs_bit_cell u_cell (
    .a    (a_sh_q[0]),
    .b    (b_sh_q[0]),
    .bin  (brw_q),
    .d    (cell_d),
    .bout (cell_bout)
  );

  // A start in DONE is accepted like one in IDLE, so back-to-back ops lose no cycle.
  assign accept   = bus.start && (state_q != RUN);
  assign last_bit = (state_q == RUN) && (cnt_q == CNT_W'(N - 1));

  always_comb begin
    // NOTE: every _d defaults to its _q first so no path leaves a signal unassigned (no latches).
    state_d = state_q;
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    res_d   = res_q;
    diff_d  = diff_q;
    cnt_d   = cnt_q;
    brw_d   = brw_q;
    bout_d  = bout_q;
    busy_d  = busy_q;
    done_d  = 1'b0;

    case (state_q)
      RUN: begin
        res_d  = {cell_d, res_q[N-1:1]};
        brw_d  = cell_bout;
        a_sh_d = a_sh_q >> 1;
        b_sh_d = b_sh_q >> 1;
        cnt_d  = cnt_q + CNT_W'(1);
        if (last_bit) begin
          state_d = DONE;
          diff_d  = {cell_d, res_q[N-1:1]};
          bout_d  = cell_bout;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      end
      default: begin
        busy_d  = 1'b0;
        state_d = IDLE;
        if (accept) begin
          state_d = RUN;
          a_sh_d  = bus.a;
          b_sh_d  = bus.b;
          brw_d   = bus.bin;
          cnt_d   = '0;
          busy_d  = 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      res_q   <= '0;
      diff_q  <= '0;
      cnt_q   <= '0;
      brw_q   <= 1'b0;
      bout_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      // NOTE: non-blocking so every flop samples the pre-edge values of the others.
      state_q <= state_d;
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      res_q   <= res_d;
      diff_q  <= diff_d;
      cnt_q   <= cnt_d;
      brw_q   <= brw_d;
      bout_q  <= bout_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.diff = diff_q;
  assign bus.bout = bout_q;

`ifdef SERIAL_SUB_OVF_EN
  // Operand MSBs are kept aside because the shift registers lose them during RUN.
  logic a_msb_q, a_msb_d;
  logic b_msb_q, b_msb_d;
  logic ovf_q, ovf_d;

  always_comb begin
    a_msb_d = a_msb_q;
    b_msb_d = b_msb_q;
    ovf_d   = ovf_q;
    if (accept) begin
      a_msb_d = bus.a[N-1];
      b_msb_d = bus.b[N-1];
    end
    if (last_bit) begin
      ovf_d = (a_msb_q != b_msb_q) && (cell_d != a_msb_q);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_msb_q <= 1'b0;
      b_msb_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      a_msb_q <= a_msb_d;
      b_msb_q <= b_msb_d;
      ovf_q   <= ovf_d;
    end
  end

  assign bus.ovf = ovf_q;
`endif

endmodule

// File: tb/tb_serial_sub_engine.sv
// Scoreboard bench for serial_sub_engine: directed N=4 cases and a random N=8
// sweep, checked by per-instance monitors against an arithmetic model.
module tb_serial_sub_engine;

  logic clk;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;

  typedef struct {
    logic [7:0] diff;
    logic       bout;
    logic       ovf;
    int         cyc;
  } exp_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Instance 0 is the N=4 directed target, instance 1 the N=8 random target.
  for (genvar g = 0; g < 2; g++) begin : inst
    localparam int W = (g == 0) ? 4 : 8;

    serial_sub_engine_if #(.N(W)) bus ();
    serial_sub_engine #(.N(W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
    );

    exp_t         q[$];
    int           n_acc = 0;
    int           n_done = 0;
    int           busy_run = 0;
    logic [W-1:0] last_diff = '0;
    logic         last_bout = 1'b0;

    always @(negedge clk) begin
      if (rst_n) begin
        if (bus.done) begin
          n_done++;
          check($sformatf("busy_at_done%0d", g), 32'(bus.busy), 32'(0));
          check($sformatf("busy_len%0d", g), 32'(busy_run), 32'(W));
          busy_run = 0;
          if (q.size() == 0) begin
            check($sformatf("unexpected_done%0d", g), 32'(1), 32'(0));
          end else begin
            exp_t e;
            e = q.pop_front();
            check($sformatf("diff%0d", g), 32'(bus.diff), 32'(e.diff[W-1:0]));
            check($sformatf("bout%0d", g), 32'(bus.bout), 32'(e.bout));
            check($sformatf("latency%0d", g), 32'(cyc), 32'(e.cyc));
`ifdef SERIAL_SUB_OVF_EN
            check($sformatf("ovf%0d", g), 32'(bus.ovf), 32'(e.ovf));
`endif
            last_diff = e.diff[W-1:0];
            last_bout = e.bout;
          end
        end
        if (bus.busy) begin
          busy_run++;
          check($sformatf("diff_hold%0d", g), 32'(bus.diff), 32'(last_diff));
          check($sformatf("bout_hold%0d", g), 32'(bus.bout), 32'(last_bout));
        end
        // Reference model: the next edge accepts this request.
        if (bus.start && !bus.busy) begin
          exp_t        e;
          int unsigned av, bv, full;
          av     = bus.a;
          bv     = bus.b;
          full   = av - bv - 32'(bus.bin);
          e.diff = 8'(full % (32'd1 << W));
          e.bout = av < (bv + 32'(bus.bin));
          e.ovf  = (bus.a[W-1] != bus.b[W-1]) && (e.diff[W-1] != bus.a[W-1]);
          e.cyc  = cyc + 1 + W;
          q.push_back(e);
          n_acc++;
        end
      end
    end
  end

  function automatic logic busy_of(input int k);
    return (k == 0) ? inst[0].bus.busy : inst[1].bus.busy;
  endfunction

  task automatic drive(input int k, input logic s, input logic [7:0] a, input logic [7:0] b,
                       input logic bi);
    if (k == 0) begin
      inst[0].bus.start = s;
      inst[0].bus.a     = a[3:0];
      inst[0].bus.b     = b[3:0];
      inst[0].bus.bin   = bi;
    end else begin
      inst[1].bus.start = s;
      inst[1].bus.a     = a;
      inst[1].bus.b     = b;
      inst[1].bus.bin   = bi;
    end
  endtask

  task automatic wait_busy(input int k, input logic want, input string name);
    for (int i = 0; i < 64; i++) begin
      @(posedge clk);
      #1;
      if (busy_of(k) == want) return;
    end
    check(name, 32'(busy_of(k)), 32'(want));
  endtask

  task automatic op(input int k, input logic [7:0] a, input logic [7:0] b, input logic bi);
    drive(k, 1'b1, a, b, bi);
    wait_busy(k, 1'b1, "op_accept_timeout");
    drive(k, 1'b0, a, b, bi);
    wait_busy(k, 1'b0, "op_finish_timeout");
  endtask

  task automatic apply_reset(input int cycles);
    rst_n = 1'b0;
    #1;
    check("rst_busy0", 32'(inst[0].bus.busy), 32'(0));
    check("rst_done0", 32'(inst[0].bus.done), 32'(0));
    check("rst_diff0", 32'(inst[0].bus.diff), 32'(0));
    check("rst_bout0", 32'(inst[0].bus.bout), 32'(0));
    check("rst_busy1", 32'(inst[1].bus.busy), 32'(0));
    check("rst_diff1", 32'(inst[1].bus.diff), 32'(0));
`ifdef SERIAL_SUB_OVF_EN
    check("rst_ovf0", 32'(inst[0].bus.ovf), 32'(0));
`endif
    inst[0].n_acc    -= inst[0].q.size();
    inst[1].n_acc    -= inst[1].q.size();
    inst[0].q.delete();
    inst[1].q.delete();
    inst[0].last_diff = '0;
    inst[0].last_bout = 1'b0;
    inst[1].last_diff = '0;
    inst[1].last_bout = 1'b0;
    inst[0].busy_run  = 0;
    inst[1].busy_run  = 0;
    repeat (cycles) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    drive(0, 1'b0, 8'd0, 8'd0, 1'b0);
    drive(1, 1'b0, 8'd0, 8'd0, 1'b0);
    #2;
    apply_reset(2);

    // Basic, borrow and borrow-in cases.
    op(0, 8'd5, 8'd3, 1'b0);
    op(0, 8'd3, 8'd5, 1'b0);
    op(0, 8'd0, 8'd0, 1'b1);

    // Start held high; operand change mid-RUN must not disturb the result.
    drive(0, 1'b1, 8'd9, 8'd4, 1'b0);
    for (int r = 0; r < 3; r++) begin
      wait_busy(0, 1'b1, "held_accept_timeout");
      drive(0, 1'b1, 8'd1, 8'd1, 1'b0);
      @(posedge clk);
      #1;
      drive(0, 1'b1, 8'd9, 8'd4, 1'b0);
      wait_busy(0, 1'b0, "held_finish_timeout");
    end
    drive(0, 1'b0, 8'd9, 8'd4, 1'b0);
    @(posedge clk);
    #1;

    // Abort mid-RUN.
    drive(0, 1'b1, 8'd6, 8'd1, 1'b0);
    wait_busy(0, 1'b1, "abort_accept_timeout");
    drive(0, 1'b0, 8'd6, 8'd1, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #1;
    apply_reset(2);
    op(0, 8'd7, 8'd2, 1'b0);

    // Signed overflow cases (ovf checked only when the feature is built in).
    op(0, 8'd7, 8'd8, 1'b0);
    op(0, 8'd2, 8'd1, 1'b0);
    op(0, 8'd8, 8'd0, 1'b1);

    // Random N=8 sweep with random idle gaps (gap 0 is back-to-back).
    for (int i = 0; i < 1000; i++) begin
      drive(1, 1'b1, 8'($urandom_range(255)), 8'($urandom_range(255)), 1'($urandom_range(1)));
      wait_busy(1, 1'b1, "rand_accept_timeout");
      drive(1, 1'b0, 8'($urandom_range(255)), 8'($urandom_range(255)), 1'($urandom_range(1)));
      wait_busy(1, 1'b0, "rand_finish_timeout");
      repeat ($urandom_range(2)) begin
        @(posedge clk);
        #1;
      end
    end

    repeat (5) @(posedge clk);
    #1;
    check("queue_empty0", 32'(inst[0].q.size()), 32'(0));
    check("queue_empty1", 32'(inst[1].q.size()), 32'(0));
    check("done_vs_accept0", 32'(inst[0].n_done), 32'(inst[0].n_acc));
    check("done_vs_accept1", 32'(inst[1].n_done), 32'(inst[1].n_acc));
    check("accept_count1", 32'(inst[1].n_acc), 32'(1000));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
